fir_mac_slice: RTL and testbench
================================

# fir_mac_slice

Sequential multiply-accumulate slice of the FIR filter, sitting directly upstream of the FIR sum stage. It holds a private delay line of input samples and a coefficient bank. On each 600 kHz sample strobe it walks its taps one multiply per clock. It then presents a saturated partial sum plus a one-cycle valid pulse, which drives the sum stage's delay/accumulate enable. Four instances, each with its own coefficient bank, feed the four sum-stage inputs.

## Interface
- NTAP, 10, taps handled by this slice
- DATA_W, 8, signed input sample width
- COEF_W, 8, signed coefficient width
- OUT_W, 16, signed partial-sum output width
- iClk12M  in  1  12 MHz system clock; one clock domain only
- iRsn  in  1  reset; synchronous, active-high (asserted = reset, sampled on iClk12M rising edge)
- iEnSample600k  in  1  one-cycle sample strobe, nominally every 20 clocks
- iFirIn  in  DATA_W  signed input sample, valid when iEnSample600k=1
- iCoeffWr  in  1  coefficient write strobe
- iCoeffAddr  in  4  tap index for coefficient write
- iCoeffData  in  COEF_W  signed coefficient value
- oMac  out  OUT_W  saturated partial sum Σ d[i]·c[i]; reset 0
- oEnDelay  out  1  one-cycle valid pulse for oMac; reset 0
- oBusy  out  1  high while in RUN or DONE; reset 0
- oOverrun  out  1  sticky; a sample strobe arrived while busy; reset 0

## Operation
- Delay line d[0..NTAP-1], where d[0] is the newest sample. Coefficient bank c[0..NTAP-1]. All are cleared to 0 on reset.
- FSM states: IDLE, RUN, DONE. The reset state is IDLE.
- IDLE with iEnSample600k=1:
  - shift the delay line (d[0]←iFirIn, d[i]←d[i-1])
  - idx←0, acc←0, go to RUN
- RUN: each clock, acc←acc + d[idx]·c[idx] and idx←idx+1. When idx=NTAP-1, go to DONE.
- DONE: oMac←sat(acc), oEnDelay←1, go to IDLE. In every other state oEnDelay←0. oMac holds its value between results.
- Arithmetic:
  - products are signed, DATA_W+COEF_W bits
  - acc is signed, DATA_W+COEF_W+4 bits (20 bits), so it never overflows internally
  - sat() clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1]
- Sample strobe in RUN or DONE: the sample is dropped, the delay line is untouched, the computation continues, and oOverrun←1 until reset.
- Coefficient write: accepted only in IDLE, and only if iCoeffAddr<NTAP. It takes effect on the next clock.
  - A write in RUN or DONE is ignored; the writer checks oBusy.
  - A write with an out-of-range address is ignored.
- Simultaneous sample strobe and coefficient write in IDLE: both are accepted. The MAC that starts uses the new coefficient.
- Reset mid-operation returns to IDLE and clears the delay line, coefficients, acc, oMac, oEnDelay and oOverrun. No partial result is emitted.

## Timing
- Strobe sampled at edge E0 → delay line shift, RUN entered.
- Edges E1..E(NTAP) perform the accumulations.
- Edge E(NTAP+1) registers oMac and raises oEnDelay for exactly one cycle.
- Latency from strobe to valid is NTAP+1 = 11 clocks. This is below the 20-clock sample period, so no overrun occurs at nominal rate.
- oBusy is high from E0+1 through the cycle in which oEnDelay is high (exclusive of the following IDLE cycle).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package fir_pkg holds:
  - NTAP, DATA_W, COEF_W, OUT_W defaults
  - derived ACC_W (DATA_W+COEF_W+4)
  - the FSM state enum (IDLE/RUN/DONE)
  - saturation limit constants
- One sub-module, fir_coeff_bank: a NTAP×COEF_W register file with guarded write port and combinational read by idx.
- The delay line, FSM, accumulator and saturation live in the top level.

## Test plan
- Reset, then all coefficients 0 and one strobe with iFirIn=5 → oEnDelay pulses 11 clocks later, oMac=0, oOverrun=0.
- c[0]=3, others 0; strobes with samples 10, 20 → results 30 then 60. c[2]=−2, then samples 1, 2, 3 → third result = 3·3 + (−2)·1 = 7.
- All c=−128 and ten samples of −128 → raw sum 163840 saturates to oMac=32767. All c=127 and samples −128 → oMac=−32768.
- Strobe 5 clocks after the previous strobe → second sample dropped, first result is unchanged, oOverrun=1 and stays set until iRsn.
- Coefficient write (addr 1, 7) while oBusy=1 → ignored, c[1] unchanged in the next result. Write to addr 12 in IDLE → ignored.
- Assert iRsn for one clock mid-RUN → no oEnDelay pulse, oMac=0, delay line cleared. The next strobe with sample 4 and c[0]=1 (rewritten) gives oMac=4.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and types for the FIR MAC slices.
//   NTAP/DATA_W/COEF_W/OUT_W : default slice geometry
//   ACC_GUARD / ACC_W        : accumulator headroom (sum of NTAP products never wraps)
//   SAT_MAX / SAT_MIN        : partial-sum clamp limits for the default OUT_W
//   mac_state_e              : slice sequencer states
package fir_pkg;

  localparam int NTAP      = 10;
  localparam int DATA_W    = 8;
  localparam int COEF_W    = 8;
  localparam int OUT_W     = 16;
  localparam int ACC_GUARD = 4;
  localparam int ACC_W     = DATA_W + COEF_W + ACC_GUARD;
  localparam int ADDR_W    = 4;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (OUT_W-1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mac_state_e;

endpackage

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: NTAP x COEF_W coefficient register file.
//   iClk12M   : system clock
//   iRsn      : synchronous active-high reset, clears every coefficient
//   wr_en     : write strobe (caller already gates it to idle cycles)
//   wr_addr   : tap index; writes at or beyond NTAP are dropped here
//   wr_data   : coefficient value
//   rd_addr   : tap index for the combinational read
//   rd_data   : coefficient at rd_addr
module fir_coeff_bank #(
  parameter int NTAP   = fir_pkg::NTAP,
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int ADDR_W = fir_pkg::ADDR_W,
  parameter int IDX_W  = 4
) (
  input  logic              iClk12M,
  input  logic              iRsn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [COEF_W-1:0] rd_data
);

  logic [NTAP-1:0][COEF_W-1:0] coef;
  logic                        addr_ok;

  // Range check keeps the address space above NTAP from aliasing onto real taps.
  assign addr_ok = int'(wr_addr) < NTAP;

  always_ff @(posedge iClk12M) begin
    if (iRsn) begin
      coef <= '0;
    end else if (wr_en && addr_ok) begin
      coef[wr_addr] <= wr_data;
    end
  end

  // rd_addr is the sequencer tap index, which never exceeds NTAP-1 while it matters.
  assign rd_data = coef[rd_addr];

endmodule

// File: rtl/fir_mac_slice.sv
// fir_mac_slice: one sequential multiply-accumulate slice of the FIR.
// A sample strobe shifts the private delay line and starts a walk over the
// taps, one product per clock; the clamped partial sum is then presented
// with a one-cycle valid pulse that enables the downstream sum stage.
//   iClk12M       : 12 MHz clock
//   iRsn          : synchronous active-high reset
//   iEnSample600k : one-cycle sample strobe
//   iFirIn        : signed sample, taken with the strobe
//   iCoeffWr      : coefficient write strobe (honoured only when idle)
//   iCoeffAddr    : coefficient tap index
//   iCoeffData    : signed coefficient value
//   oMac          : saturated partial sum, holds between results
//   oEnDelay      : one-cycle valid pulse for oMac
//   oBusy         : slice is computing (through the valid cycle)
//   oOverrun      : sticky, a strobe arrived while busy
module fir_mac_slice #(
  parameter int NTAP   = fir_pkg::NTAP,   // must be >= 2
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int OUT_W  = fir_pkg::OUT_W
) (
  input  logic              iClk12M,
  input  logic              iRsn,
  input  logic              iEnSample600k,
  input  logic [DATA_W-1:0] iFirIn,
  input  logic              iCoeffWr,
  input  logic [3:0]        iCoeffAddr,
  input  logic [COEF_W-1:0] iCoeffData,
  output logic [OUT_W-1:0]  oMac,
  output logic              oEnDelay,
  output logic              oBusy,
  output logic              oOverrun
);
  import fir_pkg::*;

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + ACC_GUARD;
  localparam int IDX_W  = $clog2(NTAP);

  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] OUT_MIN = SUM_W'(-(64'sd1 <<< (OUT_W-1)));

  mac_state_e                  state;
  logic [NTAP-1:0][DATA_W-1:0] dly;      // dly[0] is the newest sample
  logic [IDX_W-1:0]            idx;
  logic signed [SUM_W-1:0]     acc;
  logic [COEF_W-1:0]           coef_rd;
  logic signed [PROD_W-1:0]    prod;
  logic signed [SUM_W-1:0]     prod_ext;
  logic                        coef_we;

  // Writes are blocked while busy so the running sum never sees a mixed bank.
  // A write in the same idle cycle as a strobe lands before the first product.
  assign coef_we = iCoeffWr && (state == IDLE);

  fir_coeff_bank #(
    .NTAP   (NTAP),
    .COEF_W (COEF_W),
    .ADDR_W (4),
    .IDX_W  (IDX_W)
  ) u_coef (
    .iClk12M (iClk12M),
    .iRsn    (iRsn),
    .wr_en   (coef_we),
    .wr_addr (iCoeffAddr),
    .wr_data (iCoeffData),
    .rd_addr (idx),
    .rd_data (coef_rd)
  );

  assign prod     = $signed(dly[idx]) * $signed(coef_rd);
  assign prod_ext = SUM_W'(prod);

  function automatic logic [OUT_W-1:0] sat(input logic signed [SUM_W-1:0] a);
    logic [OUT_W-1:0] r;
    if (a > OUT_MAX)      r = OUT_MAX[OUT_W-1:0];
    else if (a < OUT_MIN) r = OUT_MIN[OUT_W-1:0];
    else                  r = a[OUT_W-1:0];
    return r;
  endfunction

  always_ff @(posedge iClk12M) begin
    if (iRsn) begin
      state    <= IDLE;
      dly      <= '0;
      idx      <= '0;
      acc      <= '0;
      oMac     <= '0;
      oEnDelay <= 1'b0;
      oBusy    <= 1'b0;
      oOverrun <= 1'b0;
    end else begin
      oEnDelay <= 1'b0;
      // A strobe while busy is dropped; only the flag records it.
      if (iEnSample600k && (state != IDLE)) oOverrun <= 1'b1;

      case (state)
        IDLE: begin
          oBusy <= 1'b0;
          if (iEnSample600k) begin
            dly   <= {dly[NTAP-2:0], iFirIn};
            idx   <= '0;
            acc   <= '0;
            oBusy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          oBusy <= 1'b1;
          acc   <= acc + prod_ext;
          idx   <= idx + 1'b1;
          if (idx == IDX_W'(NTAP-1)) state <= DONE;
        end
        DONE: begin
          // Busy stays high through the valid cycle that follows.
          oBusy    <= 1'b1;
          oMac     <= sat(acc);
          oEnDelay <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_slice.sv
module tb_fir_mac_slice;
  localparam int NTAP = 10;
  localparam int LAT  = NTAP + 1;

  logic       iClk12M = 1'b0;
  logic       iRsn = 1'b1;
  logic       iEnSample600k = 1'b0;
  logic [7:0] iFirIn = '0;
  logic       iCoeffWr = 1'b0;
  logic [3:0] iCoeffAddr = '0;
  logic [7:0] iCoeffData = '0;
  logic [15:0] oMac;
  logic       oEnDelay;
  logic       oBusy;
  logic       oOverrun;

  always #5 iClk12M = ~iClk12M;

  fir_mac_slice dut (
    .iClk12M       (iClk12M),
    .iRsn          (iRsn),
    .iEnSample600k (iEnSample600k),
    .iFirIn        (iFirIn),
    .iCoeffWr      (iCoeffWr),
    .iCoeffAddr    (iCoeffAddr),
    .iCoeffData    (iCoeffData),
    .oMac          (oMac),
    .oEnDelay      (oEnDelay),
    .oBusy         (oBusy),
    .oOverrun      (oOverrun)
  );

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   edge_no = 0;
  int   m_coef[NTAP];
  int   m_dly[NTAP];
  int   last_acc = -1000;
  bit   exp_ovr = 1'b0;
  bit   mon_on = 1'b0;
  int   rst_gen = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
    end
  endfunction

  function automatic int sat16(int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  task automatic tick();
    @(posedge iClk12M);
    edge_no++;
    #1;
  endtask

  // One clock of stimulus; the model decides afterwards what the DUT accepted.
  task automatic step(bit stb, int smp, bit wr, int addr, int data);
    bit idle;
    int sum;
    iEnSample600k = stb;
    iFirIn        = smp[7:0];
    iCoeffWr      = wr;
    iCoeffAddr    = addr[3:0];
    iCoeffData    = data[7:0];
    tick();
    idle = (edge_no - last_acc) > LAT;
    if (wr && idle && addr < NTAP) m_coef[addr] = data;
    if (stb) begin
      if (idle) begin
        for (int i = NTAP-1; i > 0; i--) m_dly[i] = m_dly[i-1];
        m_dly[0] = smp;
        sum = 0;
        for (int i = 0; i < NTAP; i++) sum += m_dly[i] * m_coef[i];
        sbq.push_back('{val: sat16(sum), due: edge_no + LAT});
        last_acc = edge_no;
      end else begin
        exp_ovr = 1'b1;
      end
    end
    iEnSample600k = 1'b0;
    iCoeffWr      = 1'b0;
  endtask

  task automatic wait_clks(int n);
    repeat (n) step(1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic wr(int a, int d);
    step(1'b0, 0, 1'b1, a, d);
  endtask

  // Strobe at the nominal 20-clock sample period.
  task automatic smp(int s);
    step(1'b1, s, 1'b0, 0, 0);
    wait_clks(19);
  endtask

  task automatic do_reset();
    iRsn = 1'b1;
    tick();
    iRsn = 1'b0;
    for (int i = 0; i < NTAP; i++) begin
      m_coef[i] = 0;
      m_dly[i]  = 0;
    end
    sbq.delete();
    last_acc = -1000;
    exp_ovr  = 1'b0;
    rst_gen++;
  endtask

  // Monitor: pops the scoreboard on each valid pulse and tracks the status outputs.
  int   exp_mac = 0;
  int   mon_gen = 0;
  always @(negedge iClk12M) begin
    exp_t e;
    if (mon_on && !iRsn) begin
      if (mon_gen != rst_gen) begin
        exp_mac = 0;
        mon_gen = rst_gen;
      end
      if (sbq.size() > 0 && edge_no > sbq[0].due) begin
        chk("pulse_timeout", edge_no, sbq[0].due);
        void'(sbq.pop_front());
      end
      if (oEnDelay) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("pulse_edge", edge_no, e.due);
          chk("oMac", int'($signed(oMac)), e.val);
          exp_mac = e.val;
        end
      end else begin
        chk("oMac_hold", int'($signed(oMac)), exp_mac);
      end
      chk("oBusy", int'(oBusy), int'(edge_no >= last_acc && edge_no <= last_acc + LAT));
      chk("oOverrun", int'(oOverrun), int'(exp_ovr));
    end
  end

  initial begin
    wait_clks(2);
    do_reset();
    mon_on = 1'b1;
    chk("rst_oMac", int'(oMac), 0);
    chk("rst_oEnDelay", int'(oEnDelay), 0);
    chk("rst_oBusy", int'(oBusy), 0);
    chk("rst_oOverrun", int'(oOverrun), 0);

    // Zero coefficients give zero.
    smp(5);

    // Single tap, then a two-tap pattern.
    wr(0, 3);
    smp(10);
    smp(20);
    wr(2, -2);
    smp(1);
    smp(2);
    smp(3);

    // Both saturation rails.
    for (int a = 0; a < NTAP; a++) wr(a, -128);
    repeat (NTAP) smp(-128);
    for (int a = 0; a < NTAP; a++) wr(a, 127);
    repeat (NTAP) smp(-128);

    // Overrun: second strobe 5 clocks after the first is dropped.
    do_reset();
    wr(0, 1);
    step(1'b1, 7, 1'b0, 0, 0);
    wait_clks(4);
    step(1'b1, 9, 1'b0, 0, 0);
    wait_clks(15);
    chk("overrun_sticky", int'(oOverrun), 1);

    // Write while busy ignored; strobe + write in idle both taken.
    step(1'b1, 11, 1'b0, 0, 0);
    wait_clks(2);
    wr(1, 7);
    wait_clks(17);
    step(1'b1, 3, 1'b1, 1, 2);
    wait_clks(19);
    wr(12, 5);
    smp(1);
    chk("overrun_still_set", int'(oOverrun), 1);

    // Reset in the middle of a computation.
    step(1'b1, 50, 1'b0, 0, 0);
    wait_clks(5);
    do_reset();
    chk("midrst_oMac", int'(oMac), 0);
    chk("midrst_oOverrun", int'(oOverrun), 0);
    wr(0, 1);
    smp(4);

    // Random traffic, including overruns and out-of-range writes.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(9) == 0, int'($urandom_range(255)) - 128,
           $urandom_range(4) == 0, int'($urandom_range(15)),
           int'($urandom_range(255)) - 128);
    end
    wait_clks(LAT + 4);
    chk("queue_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
